// File: rtl/countdown_timer_if.sv
// Control and display bus of the BCD countdown timer.
// The master (timer controller / bench) issues tick, start, stop and load
// requests with a preset value. The slave (the timer core) returns the
// current digits and its status flags.
interface countdown_timer_if;
    logic        enable;   // one-cycle tick pulse
    logic        start;    // one-cycle start request
    logic        stop;     // one-cycle stop/pause/acknowledge request
    logic        load;     // one-cycle load request
    logic [15:0] preset;   // BCD preset {d3,d2,d1,d0}
    logic [15:0] digits;   // current BCD value {min, 10s, s, tenths}
    logic        running;  // high while counting
    logic        expired;  // high from reaching zero until stop/load/reset
    logic        alarm;    // high for ALARM_TICKS ticks after expiry

    modport master (
        output enable, start, stop, load, preset,
        input  digits, running, expired, alarm
    );

    modport slave (
        input  enable, start, stop, load, preset,
        output digits, running, expired, alarm
    );
endinterface

// File: rtl/countdown_timer.sv
// BCD countdown timer core in M:SS.t format.
// A preset is loaded (clamped to valid BCD, at most 9:59.9). Once started,
// the value counts down by one tenth per tick. On reaching zero the timer
// flags expiry and holds alarm high for ALARM_TICKS further ticks.
// All outputs are registered. The reset is synchronous and active-high.
module countdown_timer #(
    parameter int unsigned ALARM_TICKS = 20  // legal range 1..255
) (
    input  logic               clock,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    localparam logic [7:0] ALARM_INIT = 8'(ALARM_TICKS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [15:0] digits_q,    digits_d;
    logic        running_q,   running_d;
    logic        expired_q,   expired_d;
    logic        alarm_q,     alarm_d;
    logic [7:0]  alarm_cnt_q, alarm_cnt_d;

    // Force every nibble to a legal BCD digit. Tens of seconds stop at 5.
    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [3:0] d3, d2, d1, d0;
        d3 = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
        d2 = (v[11:8]  > 4'd5) ? 4'd5 : v[11:8];
        d1 = (v[7:4]   > 4'd9) ? 4'd9 : v[7:4];
        d0 = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
        return {d3, d2, d1, d0};
    endfunction

    // Subtract one tenth through the borrow chain tenths -> s -> 10s -> min.
    // The caller never passes zero.
    function automatic logic [15:0] dec_bcd(input logic [15:0] v);
        logic [3:0] d3, d2, d1, d0;
        logic       b0, b1, b2;
        d3 = v[15:12];
        d2 = v[11:8];
        d1 = v[7:4];
        d0 = v[3:0];
        b0 = (d0 == 4'd0);
        d0 = b0 ? 4'd9 : d0 - 4'd1;
        b1 = b0 && (d1 == 4'd0);
        if (b0) d1 = (d1 == 4'd0) ? 4'd9 : d1 - 4'd1;
        b2 = b1 && (d2 == 4'd0);
        if (b1) d2 = (d2 == 4'd0) ? 4'd5 : d2 - 4'd1;
        if (b2) d3 = d3 - 4'd1;
        return {d3, d2, d1, d0};
    endfunction

    // Next-state logic. Priority: load > stop > start > enable.
    always_comb begin
        // NOTE: every _d gets a hold default first so no path infers a latch.
        state_d     = state_q;
        digits_d    = digits_q;
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;

        if (bus.load) begin
            digits_d    = clamp_bcd(bus.preset);
            state_d     = IDLE;
            alarm_d     = 1'b0;
            alarm_cnt_d = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.stop && bus.start && digits_q != 16'h0000)
                        state_d = RUN;
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = IDLE;
                    end else if (bus.enable) begin
                        if (digits_q <= 16'h0001) begin
                            digits_d    = 16'h0000;
                            state_d     = EXPIRED;
                            alarm_d     = 1'b1;
                            alarm_cnt_d = ALARM_INIT;
                        end else begin
                            digits_d = dec_bcd(digits_q);
                        end
                    end
                end
                EXPIRED: begin
                    if (bus.stop) begin
                        state_d     = IDLE;
                        alarm_d     = 1'b0;
                        alarm_cnt_d = 8'd0;
                    end else if (bus.enable && alarm_cnt_q != 8'd0) begin
                        alarm_cnt_d = alarm_cnt_q - 8'd1;
                        if (alarm_cnt_q == 8'd1) alarm_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        running_d = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q     <= IDLE;
            digits_q    <= 16'h0000;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            digits_q    <= digits_d;
            running_q   <= running_d;
            expired_q   <= expired_d;
            alarm_q     <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    assign bus.digits  = digits_q;
    assign bus.running = running_q;
    assign bus.expired = expired_q;
    assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer (ALARM_TICKS = 3).
// Stimulus drives one request set per cycle and queues the output snapshot
// expected after it. A monitor compares queued snapshots on the falling edge
// of the cycle they belong to.
module tb_countdown_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] d;
        logic        r;
        logic        e;
        logic        a;
    } exp_t;

    exp_t exp_q[$];

    countdown_timer_if bus ();

    countdown_timer #(.ALARM_TICKS(3)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input exp_t e);
        checks++;
        if ({bus.digits, bus.running, bus.expired, bus.alarm} === {e.d, e.r, e.e, e.a})
            passed++;
        else
            $display("FAIL %s: got digits=%h running=%b expired=%b alarm=%b, expected digits=%h running=%b expired=%b alarm=%b",
                     e.name, bus.digits, bus.running, bus.expired, bus.alarm,
                     e.d, e.r, e.e, e.a);
    endtask

    // Monitor: pops every snapshot due this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e);
        end
    end

    // One cycle of stimulus, applied just after the rising edge.
    task automatic drive(input logic rs, input logic en, input logic st,
                         input logic sp, input logic ld, input logic [15:0] pre);
        @(posedge clk);
        #1;
        rst        = rs;
        bus.enable = en;
        bus.start  = st;
        bus.stop   = sp;
        bus.load   = ld;
        bus.preset = pre;
    endtask

    // Queue the outputs expected once the last driven inputs are sampled.
    task automatic expect_next(input string name, input logic [15:0] d,
                               input logic r, input logic e, input logic a);
        exp_t x;
        x.cyc = cyc + 1; x.name = name; x.d = d; x.r = r; x.e = e; x.a = a;
        exp_q.push_back(x);
    endtask

    // Queue the outputs expected in the current cycle, before the last
    // driven inputs have been sampled.
    task automatic expect_now(input string name, input logic [15:0] d,
                              input logic r, input logic e, input logic a);
        exp_t x;
        x.cyc = cyc; x.name = name; x.d = d; x.r = r; x.e = e; x.a = a;
        exp_q.push_back(x);
    endtask

    task automatic do_load(input logic [15:0] pre);
        drive(0, 0, 0, 0, 1, pre);
    endtask
    task automatic do_start();  drive(0, 0, 1, 0, 0, 16'h0); endtask
    task automatic do_stop();   drive(0, 0, 0, 1, 0, 16'h0); endtask
    task automatic do_tick();   drive(0, 1, 0, 0, 0, 16'h0); endtask

    initial begin
        bus.enable = 1'b0;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.load   = 1'b0;
        bus.preset = 16'h0;

        // Reset and the first borrow across minutes.
        drive(1, 0, 0, 0, 0, 16'h0);  expect_next("reset",        16'h0000, 0, 0, 0);
        do_load(16'h1000);            expect_next("load_1000",    16'h1000, 0, 0, 0);
        do_start();                   expect_next("start_1000",   16'h1000, 1, 0, 0);
        do_tick();                    expect_now ("no_early_dec", 16'h1000, 1, 0, 0);
                                      expect_next("dec_1000",     16'h0599, 1, 0, 0);

        // Borrow from tens of seconds and from seconds.
        do_load(16'h0100);
        do_start();
        do_tick();                    expect_next("dec_0100",     16'h0099, 1, 0, 0);
        do_load(16'h0010);
        do_start();
        do_tick();                    expect_next("dec_0010",     16'h0009, 1, 0, 0);

        // Expiry and full alarm length.
        do_load(16'h0002);
        do_start();
        do_tick();                    expect_next("dec_0002",     16'h0001, 1, 0, 0);
        do_tick();                    expect_next("expire",       16'h0000, 0, 1, 1);
        do_tick();                    expect_next("alarm_t1",     16'h0000, 0, 1, 1);
        do_tick();                    expect_next("alarm_t2",     16'h0000, 0, 1, 1);
        do_tick();                    expect_next("alarm_end",    16'h0000, 0, 1, 0);
        do_tick();                    expect_next("alarm_stays",  16'h0000, 0, 1, 0);
        do_start();                   expect_next("exp_start_ign",16'h0000, 0, 1, 0);
        do_stop();                    expect_next("exp_ack",      16'h0000, 0, 0, 0);

        // Pause with a coincident tick, then resume.
        do_load(16'h0050);
        do_start();
        do_tick();
        do_tick();
        do_tick();                    expect_next("dec_0048",     16'h0047, 1, 0, 0);
        drive(0, 1, 0, 1, 0, 16'h0);  expect_next("stop_w_tick",  16'h0047, 0, 0, 0);
        do_tick();                    expect_next("idle_tick",    16'h0047, 0, 0, 0);
        do_start();                   expect_next("resume",       16'h0047, 1, 0, 0);
        do_tick();                    expect_next("dec_0047",     16'h0046, 1, 0, 0);

        // Clamping and the zero-start guard.
        do_load(16'hFAC7);            expect_next("clamp_fac7",   16'h9597, 0, 0, 0);
        do_load(16'h0000);
        do_start();                   expect_next("start_zero",   16'h0000, 0, 0, 0);

        // Load wins over start while running.
        do_load(16'h0123);
        do_start();                   expect_next("run_0123",     16'h0123, 1, 0, 0);
        drive(0, 0, 1, 0, 1, 16'h0456); expect_next("load_over_start", 16'h0456, 0, 0, 0);

        // Reset wins over a tick while running.
        do_start();
        drive(1, 1, 0, 0, 0, 16'h0);  expect_next("reset_in_run", 16'h0000, 0, 0, 0);

        // Start and tick together: no decrement that cycle; stop mid-alarm.
        do_load(16'h0001);
        drive(0, 1, 1, 0, 0, 16'h0);  expect_next("start_w_tick", 16'h0001, 1, 0, 0);
        do_tick();                    expect_next("expire_0001",  16'h0000, 0, 1, 1);
        do_stop();                    expect_next("stop_mid_alarm", 16'h0000, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 16'h0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        while (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks++;
            $display("FAIL %s: never compared, expected digits=%h", x.name, x.d);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
